// File: rtl/out_mem_sequencer_pkg.sv
// Shared definitions for the output-memory sequencer.
//  - OP_*               : command opcodes on w_cmd_op
//  - OUT_SEQ_FIFO_DEPTH : default depth of the drain output buffer
//  - seq_state_e        : sequencer FSM states
package out_mem_sequencer_pkg;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_DRAIN = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam int OUT_SEQ_FIFO_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FLUSH = 3'd4
    } seq_state_e;

endpackage

// File: rtl/out_mem_sequencer_skid_fifo.sv
// out_mem_skid_fifo: small synchronous FIFO that buffers drained rows so the
// memory's read latency is hidden behind a valid/ready stream.
// Ports:
//  clk, rst                 clock, asynchronous active-high reset
//  push, push_data/last     write one entry (ignored when full)
//  pop                      remove head entry (ignored when empty)
//  count, empty             occupancy
//  head_data, head_last     current head entry (meaningful when !empty)
module out_mem_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] last_q;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    // Pointers wrap by compare so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    // Next-state pointer and occupancy computation.
    always_comb begin
        push_ok_s = push && (count_q != CW'(DEPTH));
        pop_ok_s  = pop && (count_q != {CW{1'b0}});
        wr_ptr_d  = push_ok_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
    end

    // Control state: pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            data_q[wr_ptr_q] <= push_data;
            last_q[wr_ptr_q] <= push_last;
        end
    end

    assign count     = count_q;
    assign empty     = (count_q == {CW{1'b0}});
    assign head_data = data_q[rd_ptr_q];
    assign head_last = last_q[rd_ptr_q];

endmodule

// File: rtl/out_mem_sequencer.sv
// out_mem_sequencer: initiator for one PE's output memory. Runs CLEAR, LOAD
// (rows streamed in) and DRAIN (rows streamed out) commands.
// Ports:
//  w_clock, w_reset            clock, asynchronous active-high reset
//  w_cmd_*                     command handshake, opcode, base row, length
//  w_in_*                      LOAD beat stream
//  w_out_*                     DRAIN beat stream, w_out_last on final beat
//  w_busy, w_done              status: not idle / completion pulse
//  w_mem_*                     registered memory pins and read data return
// The memory returns read data two cycles after the read decision (one
// cycle for the registered pins, one for the memory itself); a two-stage
// pending pipeline tracks those reads and pushes them into the output FIFO.
module out_mem_sequencer
    import out_mem_sequencer_pkg::*;
#(
    parameter int OUT_MEM_NUM_ROWS   = 10,
    parameter int OUT_MEM_ADDR_WIDTH = $clog2(OUT_MEM_NUM_ROWS),
    parameter int OUT_MEM_NUM_BITS   = 16,
    parameter int FIFO_DEPTH         = OUT_SEQ_FIFO_DEPTH
) (
    input  logic                          w_clock,
    input  logic                          w_reset,
    input  logic                          w_cmd_valid,
    output logic                          w_cmd_ready,
    input  logic [1:0]                    w_cmd_op,
    input  logic [OUT_MEM_ADDR_WIDTH-1:0] w_cmd_base,
    input  logic [OUT_MEM_ADDR_WIDTH:0]   w_cmd_len,
    input  logic                          w_in_valid,
    output logic                          w_in_ready,
    input  logic [OUT_MEM_NUM_BITS-1:0]   w_in_data,
    output logic                          w_out_valid,
    input  logic                          w_out_ready,
    output logic [OUT_MEM_NUM_BITS-1:0]   w_out_data,
    output logic                          w_out_last,
    output logic                          w_busy,
    output logic                          w_done,
    output logic                          w_mem_ready,
    output logic                          w_mem_rw,
    output logic [OUT_MEM_ADDR_WIDTH-1:0] w_mem_address,
    output logic [OUT_MEM_NUM_BITS-1:0]   w_mem_data_in,
    input  logic [OUT_MEM_NUM_BITS-1:0]   w_mem_data_out
);

    localparam int AW = OUT_MEM_ADDR_WIDTH;
    localparam int NB = OUT_MEM_NUM_BITS;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0]   NUM_ROWS_L = (AW+1)'(OUT_MEM_NUM_ROWS);
    localparam logic [AW-1:0] LAST_ROW   = AW'(OUT_MEM_NUM_ROWS - 1);
    localparam logic [CW:0]   DEPTH_L    = (CW+1)'(FIFO_DEPTH);

    // Row addresses wrap by compare because NUM_ROWS need not be 2^n.
    function automatic logic [AW-1:0] next_row(input logic [AW-1:0] row);
        return (row == LAST_ROW) ? {AW{1'b0}} : row + AW'(1);
    endfunction

    seq_state_e    state_q, state_d;
    logic          mem_ready_q, mem_ready_d;
    logic          mem_rw_q, mem_rw_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [NB-1:0] mem_data_in_q, mem_data_in_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] row_q, row_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic          rd_pend1_q, rd_pend1_d, rd_last1_q, rd_last1_d;
    logic          rd_pend2_q, rd_pend2_d, rd_last2_q, rd_last2_d;

    logic [AW:0]   len_eff_s;
    logic          cmd_fire_s, in_fire_s, out_fire_s;
    logic          issue_s, issue_last_s;
    logic [CW:0]   occupancy_s;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_empty_s, fifo_last_s;
    logic [NB-1:0] fifo_data_s;

    // Next-state and next-output decision for the sequencer.
    always_comb begin
        len_eff_s   = (w_cmd_len > NUM_ROWS_L) ? NUM_ROWS_L : w_cmd_len;
        cmd_fire_s  = w_cmd_valid && cmd_ready_q;
        in_fire_s   = w_in_valid && in_ready_q;
        out_fire_s  = !fifo_empty_s && w_out_ready;
        // Buffered rows plus reads still travelling through the memory.
        occupancy_s = {1'b0, fifo_count_s} + (CW+1)'(rd_pend1_q) + (CW+1)'(rd_pend2_q);

        state_d       = state_q;
        mem_ready_d   = 1'b1;
        mem_rw_d      = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        row_d         = row_q;
        remaining_d   = remaining_q;
        done_d        = 1'b0;
        issue_s       = 1'b0;
        issue_last_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    case (w_cmd_op)
                        OP_CLEAR: begin
                            mem_ready_d = 1'b0;
                            state_d     = ST_CLEAR;
                        end
                        OP_LOAD: begin
                            if (len_eff_s == {(AW+1){1'b0}}) begin
                                done_d = 1'b1;
                            end else begin
                                state_d     = ST_LOAD;
                                row_d       = w_cmd_base;
                                remaining_d = len_eff_s;
                            end
                        end
                        OP_DRAIN: begin
                            if (len_eff_s == {(AW+1){1'b0}}) begin
                                done_d = 1'b1;
                            end else begin
                                state_d     = ST_DRAIN;
                                row_d       = w_cmd_base;
                                remaining_d = len_eff_s;
                            end
                        end
                        OP_RSVD: done_d = 1'b1;
                        default: done_d = 1'b1;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_LOAD: begin
                // remaining==0 is the cycle the final write is on the pins.
                if (remaining_q == {(AW+1){1'b0}}) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (in_fire_s) begin
                    mem_rw_d      = 1'b1;
                    mem_address_d = row_q;
                    mem_data_in_d = w_in_data;
                    row_d         = next_row(row_q);
                    remaining_d   = remaining_q - (AW+1)'(1);
                end else begin
                    mem_rw_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (occupancy_s < DEPTH_L) begin
                    issue_s       = 1'b1;
                    issue_last_s  = (remaining_q == (AW+1)'(1));
                    mem_address_d = row_q;
                    row_d         = next_row(row_q);
                    remaining_d   = remaining_q - (AW+1)'(1);
                    if (issue_last_s) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                // Done is registered, so it shows the cycle after the last pop.
                if (out_fire_s && fifo_last_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        in_ready_d  = (state_d == ST_LOAD) && (remaining_d != {(AW+1){1'b0}});
        busy_d      = (state_d != ST_IDLE);
        rd_pend1_d  = issue_s;
        rd_last1_d  = issue_last_s;
        rd_pend2_d  = rd_pend1_q;
        rd_last2_d  = rd_last1_q;
    end

    // Sequencer FSM and all registered outputs.
    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            state_q       <= ST_IDLE;
            mem_ready_q   <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_address_q <= {AW{1'b0}};
            mem_data_in_q <= {NB{1'b0}};
            cmd_ready_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            row_q         <= {AW{1'b0}};
            remaining_q   <= {(AW+1){1'b0}};
            rd_pend1_q    <= 1'b0;
            rd_last1_q    <= 1'b0;
            rd_pend2_q    <= 1'b0;
            rd_last2_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_ready_q   <= mem_ready_d;
            mem_rw_q      <= mem_rw_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            cmd_ready_q   <= cmd_ready_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            row_q         <= row_d;
            remaining_q   <= remaining_d;
            rd_pend1_q    <= rd_pend1_d;
            rd_last1_q    <= rd_last1_d;
            rd_pend2_q    <= rd_pend2_d;
            rd_last2_q    <= rd_last2_d;
        end
    end

    out_mem_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NB)
    ) u_fifo (
        .clk       (w_clock),
        .rst       (w_reset),
        .push      (rd_pend2_q),
        .push_data (w_mem_data_out),
        .push_last (rd_last2_q),
        .pop       (out_fire_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s),
        .head_data (fifo_data_s),
        .head_last (fifo_last_s)
    );

    assign w_cmd_ready   = cmd_ready_q;
    assign w_in_ready    = in_ready_q;
    assign w_out_valid   = !fifo_empty_s;
    assign w_out_data    = fifo_data_s;
    assign w_out_last    = fifo_last_s && !fifo_empty_s;
    assign w_busy        = busy_q;
    assign w_done        = done_q;
    assign w_mem_ready   = mem_ready_q;
    assign w_mem_rw      = mem_rw_q;
    assign w_mem_address = mem_address_q;
    assign w_mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_out_mem_sequencer.sv
// Self-checking bench for out_mem_sequencer with a behavioural output memory
// and a row-level reference image of what the memory should hold.
module tb_out_mem_sequencer;
    import out_mem_sequencer_pkg::*;

    localparam int NR = 10;
    localparam int AW = 4;
    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          w_reset;
    logic          w_cmd_valid, w_cmd_ready;
    logic [1:0]    w_cmd_op;
    logic [AW-1:0] w_cmd_base;
    logic [AW:0]   w_cmd_len;
    logic          w_in_valid, w_in_ready;
    logic [NB-1:0] w_in_data;
    logic          w_out_valid, w_out_ready, w_out_last;
    logic [NB-1:0] w_out_data;
    logic          w_busy, w_done;
    logic          w_mem_ready, w_mem_rw;
    logic [AW-1:0] w_mem_address;
    logic [NB-1:0] w_mem_data_in;
    logic [NB-1:0] mem_dout;

    always #5 clk = ~clk;

    out_mem_sequencer #(
        .OUT_MEM_NUM_ROWS (NR),
        .OUT_MEM_NUM_BITS (NB),
        .FIFO_DEPTH       (4)
    ) dut (
        .w_clock        (clk),
        .w_reset        (w_reset),
        .w_cmd_valid    (w_cmd_valid),
        .w_cmd_ready    (w_cmd_ready),
        .w_cmd_op       (w_cmd_op),
        .w_cmd_base     (w_cmd_base),
        .w_cmd_len      (w_cmd_len),
        .w_in_valid     (w_in_valid),
        .w_in_ready     (w_in_ready),
        .w_in_data      (w_in_data),
        .w_out_valid    (w_out_valid),
        .w_out_ready    (w_out_ready),
        .w_out_data     (w_out_data),
        .w_out_last     (w_out_last),
        .w_busy         (w_busy),
        .w_done         (w_done),
        .w_mem_ready    (w_mem_ready),
        .w_mem_rw       (w_mem_rw),
        .w_mem_address  (w_mem_address),
        .w_mem_data_in  (w_mem_data_in),
        .w_mem_data_out (mem_dout)
    );

    // Output memory: ready low clears, rw=1 writes, rw=0 reads with one-cycle latency.
    logic [NB-1:0] mem [NR];
    always @(posedge clk) begin
        if (!w_mem_ready) begin
            for (int i = 0; i < NR; i++) mem[i] <= '0;
        end else if (w_mem_rw) begin
            if (int'(w_mem_address) < NR) mem[w_mem_address] <= w_mem_data_in;
        end else begin
            if (int'(w_mem_address) < NR) mem_dout <= mem[w_mem_address];
        end
    end

    // Event counters over the cycle that ends at each rising edge.
    int done_cnt, low_cnt, wr_cnt;
    always @(posedge clk) begin
        if (w_done) done_cnt++;
        if (!w_mem_ready && !w_reset) low_cnt++;
        if (w_mem_rw) wr_cnt++;
    end

    int n_assert = 0;
    int n_fail   = 0;
    logic [NB-1:0] ref_mem [NR];
    logic [NB-1:0] load_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < NR; i++) chk($sformatf("%s_row%0d", tag, i), mem[i], ref_mem[i]);
    endtask

    task automatic send_cmd(input logic [1:0] op, input int base, input int len);
        int t;
        t = 0;
        while (w_cmd_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        chk("cmd_ready_wait", (t < 50), 1);
        w_cmd_valid = 1'b1;
        w_cmd_op    = op;
        w_cmd_base  = AW'(base);
        w_cmd_len   = (AW+1)'(len);
        @(negedge clk);
        w_cmd_valid = 1'b0;
    endtask

    task automatic do_load(input int base, input int len, input int max_gap);
        int n, t, tmo;
        n = (len > NR) ? NR : len;
        tmo = 0;
        wr_cnt = 0; done_cnt = 0;
        send_cmd(OP_LOAD, base, len);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            w_in_valid = 1'b1;
            w_in_data  = load_q[k];
            t = 0;
            while (w_in_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
            if (t >= 20) tmo++;
            @(negedge clk);
            w_in_valid = 1'b0;
            ref_mem[(base + k) % NR] = load_q[k];
        end
        chk("load_in_ready_timeout", tmo, 0);
        chk("load_in_ready_drop", w_in_ready, 0);
        chk("load_done_early", w_done, 0);
        @(negedge clk);
        chk("load_done", w_done, 1);
        chk("load_busy_end", w_busy, 0);
        @(negedge clk);
        chk("load_done_count", done_cnt, 1);
        chk("load_write_count", wr_cnt, n);
        check_mem("load_mem");
    endtask

    task automatic do_drain(input int base, input int len, input int ready_pct);
        int n, idx, t;
        logic stall, hold_l;
        logic [NB-1:0] hold_d;
        n = (len > NR) ? NR : len;
        idx = 0; t = 0; stall = 1'b0; hold_l = 1'b0; hold_d = '0;
        wr_cnt = 0; low_cnt = 0; done_cnt = 0;
        send_cmd(OP_DRAIN, base, len);
        while (idx < n && t < 500) begin
            if (stall) begin
                chk("out_hold_valid", w_out_valid, 1);
                chk("out_hold_data", w_out_data, hold_d);
                chk("out_hold_last", w_out_last, hold_l);
            end
            w_out_ready = ($urandom_range(0, 99) < ready_pct);
            if (w_out_valid && w_out_ready) begin
                chk($sformatf("drain_data_b%0d_k%0d", base, idx), w_out_data, ref_mem[(base + idx) % NR]);
                chk($sformatf("drain_last_k%0d", idx), w_out_last, (idx == n - 1));
                idx++;
                stall = 1'b0;
            end else begin
                stall  = w_out_valid;
                hold_d = w_out_data;
                hold_l = w_out_last;
            end
            @(negedge clk);
            t++;
        end
        w_out_ready = 1'b0;
        chk("drain_beats", idx, n);
        chk("drain_done", w_done, 1);
        chk("drain_busy_end", w_busy, 0);
        chk("drain_out_empty", w_out_valid, 0);
        @(negedge clk);
        chk("drain_done_count", done_cnt, 1);
        chk("drain_no_writes", wr_cnt, 0);
        chk("drain_no_clear", low_cnt, 0);
    endtask

    task automatic null_cmd(input string tag, input logic [1:0] op, input int len);
        wr_cnt = 0; low_cnt = 0; done_cnt = 0;
        send_cmd(op, 3, len);
        chk({tag, "_done"}, w_done, 1);
        chk({tag, "_busy"}, w_busy, 0);
        chk({tag, "_cmd_ready"}, w_cmd_ready, 1);
        chk({tag, "_mem_ready"}, w_mem_ready, 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, w_done, 0);
        @(negedge clk);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_no_writes"}, wr_cnt, 0);
        chk({tag, "_no_clear"}, low_cnt, 0);
    endtask

    task automatic fill_random(input int n);
        load_q.delete();
        for (int i = 0; i < n; i++) load_q.push_back(NB'($urandom_range(0, 65535)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        w_reset = 1'b1; w_cmd_valid = 1'b0; w_cmd_op = 2'b00; w_cmd_base = '0; w_cmd_len = '0;
        w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b0;
        for (int i = 0; i < NR; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_mem_ready", w_mem_ready, 0);
        chk("rst_mem_rw", w_mem_rw, 0);
        chk("rst_mem_address", w_mem_address, 0);
        chk("rst_mem_data_in", w_mem_data_in, 0);
        chk("rst_cmd_ready", w_cmd_ready, 0);
        chk("rst_in_ready", w_in_ready, 0);
        chk("rst_out_valid", w_out_valid, 0);
        chk("rst_out_last", w_out_last, 0);
        chk("rst_busy", w_busy, 0);
        chk("rst_done", w_done, 0);
        w_reset = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", w_cmd_ready, 1);
        chk("idle_mem_ready", w_mem_ready, 1);
        chk("idle_mem_rw", w_mem_rw, 0);

        // CLEAR: one low cycle on mem_ready, then a single done pulse.
        low_cnt = 0; done_cnt = 0;
        send_cmd(OP_CLEAR, 0, 0);
        chk("clr_mem_ready_low", w_mem_ready, 0);
        chk("clr_busy", w_busy, 1);
        chk("clr_done_early", w_done, 0);
        @(negedge clk);
        chk("clr_mem_ready_back", w_mem_ready, 1);
        chk("clr_done", w_done, 1);
        @(negedge clk);
        chk("clr_done_pulse", w_done, 0);
        chk("clr_cmd_ready", w_cmd_ready, 1);
        chk("clr_low_cycles", low_cnt, 1);
        chk("clr_done_count", done_cnt, 1);
        check_mem("clr_mem");

        // LOAD with gaps, fixed data.
        load_q = '{NB'(11), NB'(22), NB'(33), NB'(44)};
        do_load(0, 4, 2);

        // LOAD and DRAIN across the address wrap.
        fill_random(4);
        do_load(NR - 2, 4, 1);
        do_drain(NR - 2, 4, 100);

        // Oversized length clamps to every row once.
        fill_random(NR);
        do_load(5, 31, 0);
        do_drain(0, NR, 50);
        do_drain(7, 20, 50);

        // Zero-length and reserved commands.
        null_cmd("drain_len0", OP_DRAIN, 0);
        null_cmd("load_len0", OP_LOAD, 0);
        null_cmd("op_rsvd", OP_RSVD, 5);

        // CLEAR after data, confirmed by memory image and a short drain.
        send_cmd(OP_CLEAR, 0, 0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < NR; i++) ref_mem[i] = '0;
        check_mem("clr2_mem");
        do_drain(0, 3, 100);

        // Asynchronous reset in the middle of a stalled DRAIN.
        fill_random(NR);
        do_load(0, NR, 0);
        w_out_ready = 1'b0;
        done_cnt = 0;
        send_cmd(OP_DRAIN, 0, NR);
        repeat (10) @(negedge clk);
        chk("abort_pre_valid", w_out_valid, 1);
        chk("abort_pre_busy", w_busy, 1);
        chk("abort_pre_head", w_out_data, ref_mem[0]);
        #2;
        w_reset = 1'b1;
        #1;
        chk("abort_out_valid", w_out_valid, 0);
        chk("abort_busy", w_busy, 0);
        chk("abort_mem_ready", w_mem_ready, 0);
        chk("abort_cmd_ready", w_cmd_ready, 0);
        repeat (2) @(negedge clk);
        w_reset = 1'b0;
        @(negedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_cmd_ready_back", w_cmd_ready, 1);
        for (int i = 0; i < NR; i++) ref_mem[i] = '0;
        check_mem("abort_mem");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
